mouse_stim_gen: RTL and testbench

MOUSE_STIM_GEN -- requirements
Module: mouse_stim_gen

---
 rtl/mouse_stim_if.sv | 27 ++
 rtl/mouse_stim_gen.sv | 152 +++++++++++++++
 tb/tb_mouse_stim_gen.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mouse_stim_if.sv
// mouse_stim_if -- control and cursor-output bundle for mouse_stim_gen.
//   enable, tick, mode : stimulus controls driven by the master side.
//   mouse_left         : left button, 1 = pressed.
//   mouse_xpos/ypos    : cursor position, XY_W bits each.
//   wrap_pulse         : one-cycle pulse when a full raster completes.
// The generator itself is the slave; whoever drives the controls is the master.
interface mouse_stim_if #(
  parameter int XY_W = 12
);
  logic            enable;
  logic            tick;
  logic [1:0]      mode;
  logic            mouse_left;
  logic [XY_W-1:0] mouse_xpos;
  logic [XY_W-1:0] mouse_ypos;
  logic            wrap_pulse;

  modport master (
    output enable, tick, mode,
    input  mouse_left, mouse_xpos, mouse_ypos, wrap_pulse
  );

  modport slave (
    input  enable, tick, mode,
    output mouse_left, mouse_xpos, mouse_ypos, wrap_pulse
  );
endinterface

// File: rtl/mouse_stim_gen.sv
// mouse_stim_gen -- synthetic mouse stimulus for display/UI testing.
// On each enabled tick the cursor moves according to mode:
//   HOLD   : stay put, button released.
//   RASTER : left-to-right, top-to-bottom scan, wrap_pulse on full-frame wrap.
//   BOUNCE : each axis moves independently and reflects at 0 and its max.
//   CLICK  : BOUNCE motion plus a periodic left-button press pattern.
// Ports:
//   clk   : single clock, all state on its rising edge.
//   rst_n : asynchronous active-low reset.
//   bus   : mouse_stim_if slave modport (controls in, cursor/button out).
module mouse_stim_gen #(
  parameter int XY_W         = 12,
  parameter int X_MAX        = 799,
  parameter int Y_MAX        = 599,
  parameter int STEP         = 4,
  parameter int X_START      = 0,
  parameter int Y_START      = 0,
  parameter int CLICK_PERIOD = 16,
  parameter int CLICK_LEN    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  mouse_stim_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'd0,
    MODE_RASTER = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_CLICK  = 2'd3
  } mode_e;

  // One extra bit so pos+STEP can never overflow before the range check.
  localparam int W     = XY_W + 1;
  localparam int CNT_W = (CLICK_PERIOD > 2) ? $clog2(CLICK_PERIOD) : 1;

  localparam logic [W-1:0]     STEP_E   = W'(STEP);
  localparam logic [XY_W-1:0]  STEP_N   = XY_W'(STEP);
  localparam logic [W-1:0]     X_MAX_E  = W'(X_MAX);
  localparam logic [W-1:0]     Y_MAX_E  = W'(Y_MAX);
  localparam logic [XY_W-1:0]  X_RST    = XY_W'(X_START);
  localparam logic [XY_W-1:0]  Y_RST    = XY_W'(Y_START);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLICK_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_LEN  = CNT_W'(CLICK_LEN);

  logic [XY_W-1:0]  x_q, x_d, y_q, y_d;
  logic             x_dir_q, x_dir_d, y_dir_q, y_dir_d;
  logic             left_q, left_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] click_cnt_q, click_cnt_d;
  mode_e            mode_prev_q, mode_prev_d;

  // Raster axis step: returns {wrapped, new_pos}.
  function automatic logic [XY_W:0] raster_step(input logic [XY_W-1:0] pos,
                                                input logic [W-1:0]    lim);
    if (({1'b0, pos} + STEP_E) > lim) return {1'b1, {XY_W{1'b0}}};
    return {1'b0, pos + STEP_N};
  endfunction

  // Bounce axis step: dir 0 = moving +, 1 = moving -. Returns {new_dir, new_pos}.
  function automatic logic [XY_W:0] bounce_step(input logic [XY_W-1:0] pos,
                                                input logic            dir,
                                                input logic [W-1:0]    lim);
    if (!dir) begin
      if (({1'b0, pos} + STEP_E) > lim) return {1'b1, lim[XY_W-1:0]};
      return {1'b0, pos + STEP_N};
    end
    if ({1'b0, pos} < STEP_E) return {1'b0, {XY_W{1'b0}}};
    return {1'b1, pos - STEP_N};
  endfunction

  mode_e            mode_in;
  logic             step;
  logic [CNT_W-1:0] cnt_base, cnt_next;
  logic [XY_W:0]    rx, ry, bx, by;

  // Next-state logic. A mode change is detected against the mode of the last
  // step, so the click counter restarts before it advances on that same step.
  always_comb begin
    mode_in  = mode_e'(bus.mode);
    step     = bus.enable & bus.tick;
    cnt_base = (mode_in != mode_prev_q) ? '0 : click_cnt_q;
    cnt_next = (cnt_base == CNT_LAST) ? '0 : cnt_base + 1'b1;
    rx       = raster_step(x_q, X_MAX_E);
    ry       = raster_step(y_q, Y_MAX_E);
    bx       = bounce_step(x_q, x_dir_q, X_MAX_E);
    by       = bounce_step(y_q, y_dir_q, Y_MAX_E);

    x_d         = x_q;
    y_d         = y_q;
    x_dir_d     = x_dir_q;
    y_dir_d     = y_dir_q;
    left_d      = left_q;
    wrap_d      = 1'b0;
    click_cnt_d = click_cnt_q;
    mode_prev_d = mode_prev_q;

    if (step) begin
      mode_prev_d = mode_in;
      click_cnt_d = cnt_next;
      left_d      = 1'b0;
      unique case (mode_in)
        MODE_HOLD: begin
        end
        MODE_RASTER: begin
          x_d = rx[XY_W-1:0];
          // y only advances on an x wrap; both wrapping closes the frame.
          if (rx[XY_W]) begin
            y_d    = ry[XY_W-1:0];
            wrap_d = ry[XY_W];
          end
        end
        MODE_BOUNCE, MODE_CLICK: begin
          x_d     = bx[XY_W-1:0];
          x_dir_d = bx[XY_W];
          y_d     = by[XY_W-1:0];
          y_dir_d = by[XY_W];
          left_d  = (mode_in == MODE_CLICK) && (cnt_next != '0) &&
                    (cnt_next <= CNT_LEN);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= X_RST;
      y_q         <= Y_RST;
      x_dir_q     <= 1'b0;
      y_dir_q     <= 1'b0;
      left_q      <= 1'b0;
      wrap_q      <= 1'b0;
      click_cnt_q <= '0;
      mode_prev_q <= MODE_HOLD;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      x_dir_q     <= x_dir_d;
      y_dir_q     <= y_dir_d;
      left_q      <= left_d;
      wrap_q      <= wrap_d;
      click_cnt_q <= click_cnt_d;
      mode_prev_q <= mode_prev_d;
    end
  end

  assign bus.mouse_xpos = x_q;
  assign bus.mouse_ypos = y_q;
  assign bus.mouse_left = left_q;
  assign bus.wrap_pulse = wrap_q;

endmodule

// File: tb/tb_mouse_stim_gen.sv
`timescale 1ns/1ps
module tb_mouse_stim_gen;

  localparam logic [1:0] M_HOLD   = 2'd0;
  localparam logic [1:0] M_RASTER = 2'd1;
  localparam logic [1:0] M_BOUNCE = 2'd2;
  localparam logic [1:0] M_CLICK  = 2'd3;

  // Default-parameter geometry: 200 raster columns, 150 rows.
  localparam int XN = 200;
  localparam int YN = 150;

  typedef struct packed {
    logic        chk;
    logic [11:0] x;
    logic [11:0] y;
    logic        left;
    logic        wrap;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  exp_t  sb[$];
  string sb_name[$];
  event  async_ev;

  mouse_stim_if #(.XY_W(12)) bus();

  mouse_stim_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Closed-form raster position after n ticks from the origin.
  function automatic int raster_x(input int n);
    return (n % XN) * 4;
  endfunction

  function automatic int raster_y(input int n);
    return ((n / XN) % YN) * 4;
  endfunction

  // Closed-form bounce position after n ticks from 0 moving +, step 4, for a
  // max with max%4==3: up 0,4,..,4*(U-1), max, then down max-4k to 3, then 0.
  function automatic int bounce_pos(input int n, input int mx);
    int u;
    int p;
    u = mx / 4 + 1;
    p = n % (2 * u);
    if (p < u) return 4 * p;
    return mx - 4 * (p - u);
  endfunction

  // Compare one scoreboard entry against the live DUT outputs.
  task automatic checkOutput(input exp_t e, input string nm);
    if (e.chk) begin
      total++;
      if (bus.mouse_xpos !== e.x || bus.mouse_ypos !== e.y ||
          bus.mouse_left !== e.left || bus.wrap_pulse !== e.wrap) begin
        bad++;
        $display("[TB] FAIL %s: got x=%0d y=%0d left=%0b wrap=%0b, expected x=%0d y=%0d left=%0b wrap=%0b",
                 nm, bus.mouse_xpos, bus.mouse_ypos, bus.mouse_left, bus.wrap_pulse,
                 e.x, e.y, e.left, e.wrap);
      end
    end
  endtask

  // Drive one cycle's inputs, queue the expected post-edge outputs, advance.
  task automatic applyStimulus(input bit en, input bit tk, input logic [1:0] md,
                               input bit chk, input int ex, input int ey,
                               input bit el, input bit ew, input string nm);
    exp_t e;
    bus.enable = en;
    bus.tick   = tk;
    bus.mode   = md;
    e.chk  = chk;
    e.x    = 12'(ex);
    e.y    = 12'(ey);
    e.left = el;
    e.wrap = ew;
    sb.push_back(e);
    sb_name.push_back(nm);
    @(posedge clk);
    #2;
  endtask

  // Pull reset low between edges and expect reset outputs before any edge.
  task automatic asyncReset();
    exp_t e;
    #1;
    rst_n = 1'b0;
    #1;
    e.chk  = 1'b1;
    e.x    = 12'd0;
    e.y    = 12'd0;
    e.left = 1'b0;
    e.wrap = 1'b0;
    sb.push_back(e);
    sb_name.push_back("async reset mid-cycle");
    -> async_ev;
    @(posedge clk);
    #2;
  endtask

  // Monitor: outputs are presented 1 ns after each edge, or shortly after an
  // asynchronous reset; pop one expectation whenever one is pending.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk or async_ev);
      #1;
      if (sb.size() != 0) begin
        e  = sb.pop_front();
        nm = sb_name.pop_front();
        checkOutput(e, nm);
      end
    end
  end

  initial begin
    bit   c;
    int   nb;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.enable = 1'b0;
    bus.tick   = 1'b0;
    bus.mode   = M_HOLD;
    @(posedge clk);
    #2;

    applyStimulus(0, 0, M_HOLD, 1, 0, 0, 0, 0, "reset state");
    applyStimulus(1, 1, M_RASTER, 1, 0, 0, 0, 0, "reset held with tick");
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      applyStimulus(0, 1, M_RASTER, 1, 0, 0, 0, 0, "freeze enable=0");

    // Raster up to (400,300), then async reset between edges.
    for (int n = 1; n <= 15100; n++) begin
      c = (n == 1) || (n == 199) || (n == 200) || (n == 201) || (n == 15100);
      applyStimulus(1, 1, M_RASTER, c, raster_x(n), raster_y(n), 0, 0, "raster walk");
    end
    asyncReset();
    applyStimulus(1, 1, M_RASTER, 1, 0, 0, 0, 0, "reset held in raster");
    rst_n = 1'b1;

    // Full raster from origin: row wrap and frame wrap.
    for (int n = 1; n <= 30000; n++) begin
      c = (n == 1) || (n == 5099) || (n == 5100) || (n == 29999) || (n == 30000);
      applyStimulus(1, 1, M_RASTER, c, raster_x(n), raster_y(n), 0,
                    (n == 30000), "raster wrap");
    end
    applyStimulus(1, 0, M_RASTER, 1, 0, 0, 0, 0, "no tick after frame wrap");
    applyStimulus(1, 1, M_RASTER, 1, 4, 0, 0, 0, "raster after frame wrap");

    rst_n = 1'b0;
    applyStimulus(0, 0, M_BOUNCE, 1, 0, 0, 0, 0, "reset before bounce");
    rst_n = 1'b1;

    // Bounce: y turns at 596->599->595 and 3->0->4; x at 796->799->795, 3->0->4.
    for (int n = 1; n <= 401; n++) begin
      c = (n == 1) || (n == 149) || (n == 150) || (n == 151) || (n == 199) ||
          (n == 200) || (n == 201) || (n == 299) || (n == 300) || (n == 301) ||
          (n == 399) || (n == 400) || (n == 401);
      applyStimulus(1, 1, M_BOUNCE, c, bounce_pos(n, 799), bounce_pos(n, 599),
                    0, 0, "bounce edge");
    end

    // Click: press after ticks 1,2,17,18,33,34; motion continues as bounce.
    for (int k = 1; k <= 34; k++) begin
      nb = 401 + k;
      applyStimulus(1, 1, M_CLICK, 1, bounce_pos(nb, 799), bounce_pos(nb, 599),
                    (k == 1) || (k == 2) || (k == 17) || (k == 18) ||
                    (k == 33) || (k == 34), 0, "click pattern");
    end

    for (int i = 0; i < 10; i++)
      applyStimulus(0, 1, M_CLICK, 1, bounce_pos(435, 799), bounce_pos(435, 599),
                    1, 0, "freeze in click");

    for (int i = 0; i < 5; i++)
      applyStimulus(1, 1, M_HOLD, 1, bounce_pos(435, 799), bounce_pos(435, 599),
                    0, 0, "hold with ticks");

    applyStimulus(1, 1, M_CLICK, 1, bounce_pos(436, 799), bounce_pos(436, 599),
                  1, 0, "hold to click tick 1");
    applyStimulus(1, 1, M_CLICK, 1, bounce_pos(437, 799), bounce_pos(437, 599),
                  1, 0, "hold to click tick 2");
    applyStimulus(1, 1, M_CLICK, 1, bounce_pos(438, 799), bounce_pos(438, 599),
                  0, 0, "hold to click tick 3");

    bus.enable = 1'b0;
    bus.tick   = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
